// File: rtl/register_file_multiport_pkg.sv
// Shared definitions for the multiported register file.
// Holds the default geometry, the select-width helper and the word/index
// typedefs used by register_file_multiport and its bypass mux.
package PkgRegisterFileMp;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_NUM_REGS        = 16;
  localparam int DEF_NUM_READ_PORTS  = 3;
  localparam int DEF_NUM_WRITE_PORTS = 2;

  // Width of a register index; a one-entry file still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0]       data_word_t;

endpackage

// File: rtl/register_file_multiport_bypass_mux.sv
// Write-to-read bypass selector for one read port (purely combinational).
// Ports:
//   rd_sel_i    register addressed by the read port
//   wr_en_i     write strobes of all write ports
//   wr_sel_i    packed write addresses, port w at [w*SEL_W +: SEL_W]
//   wr_data_i   packed write data, port w at [w*DATA_WIDTH +: DATA_WIDTH]
//   byp_data_o  data from the winning write port (0 when no hit)
//   byp_hit_o   some enabled write port targets rd_sel_i (never for reg 0)
module reg_file_bypass_mux #(
  parameter int DATA_WIDTH      = 32,
  parameter int SEL_W           = 4,
  parameter int NUM_WRITE_PORTS = 2
) (
  input  logic [SEL_W-1:0]                      rd_sel_i,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_en_i,
  input  logic [NUM_WRITE_PORTS*SEL_W-1:0]      wr_sel_i,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0]                 byp_data_o,
  output logic                                  byp_hit_o
);

  // Ascending scan: a later (higher-index) match overrides an earlier one,
  // which gives the highest-index port priority.
  always_comb begin
    byp_data_o = '0;
    byp_hit_o  = 1'b0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (wr_en_i[w] && (rd_sel_i != '0) &&
          (wr_sel_i[w*SEL_W +: SEL_W] == rd_sel_i)) begin
        byp_data_o = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
        byp_hit_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_file_multiport.sv
// Multiported register file for the Frost32 pipeline.
// N registered read ports with write-to-read bypass, M write ports
// (higher index wins on collision), register 0 hardwired to zero, and an
// optional per-register pending-write scoreboard.
// Configuration macro: REG_FILE_SCOREBOARD_EN
//   defined   -> busy flops exist; claims set, write-backs clear.
//   undefined -> busy_vec / rd_busy tied to 0, claim inputs ignored.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rd_en/rd_sel        per-port read strobe and address
//   rd_data/rd_busy     registered read data and pending flag (hold when !rd_en)
//   wr_en/wr_sel/wr_data per-port write strobe, address, data
//   claim_en/claim_sel  mark a register pending at issue
//   busy_vec            registered scoreboard, bit r = reg r pending
// All strobes are single-cycle qualifiers with no backpressure: an asserted
// strobe at a posedge is always accepted in that cycle.
module register_file_multiport
  import PkgRegisterFileMp::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int NUM_REGS        = DEF_NUM_REGS,
  parameter int NUM_READ_PORTS  = DEF_NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = DEF_NUM_WRITE_PORTS,
  localparam int SEL_W          = sel_w(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_READ_PORTS-1:0]             rd_en,
  input  logic [NUM_READ_PORTS*SEL_W-1:0]       rd_sel,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ_PORTS-1:0]             rd_busy,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_en,
  input  logic [NUM_WRITE_PORTS*SEL_W-1:0]      wr_sel,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                                  claim_en,
  input  logic [SEL_W-1:0]                      claim_sel,
  output logic [NUM_REGS-1:0]                   busy_vec
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] byp_data [NUM_READ_PORTS];
  logic                  byp_hit  [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_data_q [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_data_d [NUM_READ_PORTS];

  // Storage update; ascending order lets the highest-index port win.
  // Reg 0 is never written, so regs_q[0] stays 0 from reset.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (wr_en[w] && (wr_sel[w*SEL_W +: SEL_W] != '0)) begin
        regs_d[wr_sel[w*SEL_W +: SEL_W]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    reg_file_bypass_mux #(
      .DATA_WIDTH      (DATA_WIDTH),
      .SEL_W           (SEL_W),
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
    ) u_byp (
      .rd_sel_i   (rd_sel[p*SEL_W +: SEL_W]),
      .wr_en_i    (wr_en),
      .wr_sel_i   (wr_sel),
      .wr_data_i  (wr_data),
      .byp_data_o (byp_data[p]),
      .byp_hit_o  (byp_hit[p])
    );
  end

  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_data_d[p] = rd_data_q[p];
      if (rd_en[p]) begin
        rd_data_d[p] = byp_hit[p] ? byp_data[p] : regs_q[rd_sel[p*SEL_W +: SEL_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      for (int p = 0; p < NUM_READ_PORTS; p++) rd_data_q[p] <= '0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[p];
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic [NUM_READ_PORTS-1:0] rd_busy_q, rd_busy_d;
  logic                      wr_hit;

  // Claim has priority over a same-cycle write-back so a re-issued
  // destination stays pending.
  always_comb begin
    busy_d = busy_q;
    wr_hit = 1'b0;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      wr_hit = 1'b0;
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_en[w] && (wr_sel[w*SEL_W +: SEL_W] == SEL_W'(r))) wr_hit = 1'b1;
      end
      if (claim_en && (claim_sel == SEL_W'(r))) busy_d[r] = 1'b1;
      else if (wr_hit)                          busy_d[r] = 1'b0;
    end
  end

  // Reading the next-state busy gives rd_busy the same bypass as data.
  always_comb begin
    rd_busy_d = rd_busy_q;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (rd_en[p]) rd_busy_d[p] = busy_d[rd_sel[p*SEL_W +: SEL_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rd_busy_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign busy_vec = busy_q;
  assign rd_busy  = rd_busy_q;
`else
  logic unused_claim;
  assign unused_claim = ^{claim_en, claim_sel};
  assign busy_vec     = '0;
  assign rd_busy      = '0;
`endif

endmodule

// File: tb/tb_register_file_multiport.sv
module tb_register_file_multiport;
  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int NRP = 3;
  localparam int NWP = 2;
  localparam int SW  = 4;
`ifdef REG_FILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NRP-1:0]     rd_en;
  logic [NRP*SW-1:0]  rd_sel;
  logic [NRP*DW-1:0]  rd_data;
  logic [NRP-1:0]     rd_busy;
  logic [NWP-1:0]     wr_en;
  logic [NWP*SW-1:0]  wr_sel;
  logic [NWP*DW-1:0]  wr_data;
  logic               claim_en;
  logic [SW-1:0]      claim_sel;
  logic [NR-1:0]      busy_vec;

  register_file_multiport dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .claim_en  (claim_en),
    .claim_sel (claim_sel),
    .busy_vec  (busy_vec)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_reg  [NR];
  bit            m_busy [NR];
  logic [DW-1:0] m_rd_data [NRP];
  bit            m_rd_busy [NRP];

  always @(posedge clk) begin
    bit            nb [NR];
    bit            done [NR];
    bit            found;
    int            s;
    int            t;
    logic [DW-1:0] val;
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
      for (int p = 0; p < NRP; p++) begin m_rd_data[p] = '0; m_rd_busy[p] = 0; end
    end else begin
      for (int r = 0; r < NR; r++) begin
        nb[r] = m_busy[r];
        done[r] = 0;
        if (r != 0) begin
          found = 0;
          for (int w = 0; w < NWP; w++)
            if (wr_en[w] && int'(wr_sel[w*SW +: SW]) == r) found = 1;
          if (SB && claim_en && int'(claim_sel) == r) nb[r] = 1;
          else if (found) nb[r] = 0;
        end
      end
      for (int p = 0; p < NRP; p++) begin
        if (rd_en[p]) begin
          s = int'(rd_sel[p*SW +: SW]);
          val = '0;
          if (s != 0) begin
            found = 0;
            for (int w = NWP-1; w >= 0; w--) begin
              if (!found && wr_en[w] && int'(wr_sel[w*SW +: SW]) == s) begin
                val = wr_data[w*DW +: DW];
                found = 1;
              end
            end
            if (!found) val = m_reg[s];
          end
          m_rd_data[p] = val;
          m_rd_busy[p] = nb[s];
        end
      end
      // Highest-priority port claims its target first; lower ports may not overwrite.
      for (int w = NWP-1; w >= 0; w--) begin
        t = int'(wr_sel[w*SW +: SW]);
        if (wr_en[w] && t != 0 && !done[t]) begin
          m_reg[t] = wr_data[w*DW +: DW];
          done[t] = 1;
        end
      end
      for (int r = 0; r < NR; r++) m_busy[r] = nb[r];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NR-1:0] mv;
    if (cmp_on) begin
      for (int r = 0; r < NR; r++) mv[r] = m_busy[r];
      checks++;
      if (busy_vec !== mv) begin
        failures++;
        $display("FAIL busy_vec t=%0t got=%h exp=%h", $time, busy_vec, mv);
      end
      for (int p = 0; p < NRP; p++) begin
        checks++;
        if (rd_data[p*DW +: DW] !== m_rd_data[p]) begin
          failures++;
          $display("FAIL rd_data[%0d] t=%0t got=%h exp=%h", p, $time, rd_data[p*DW +: DW], m_rd_data[p]);
        end
        checks++;
        if (rd_busy[p] !== m_rd_busy[p]) begin
          failures++;
          $display("FAIL rd_busy[%0d] t=%0t got=%b exp=%b", p, $time, rd_busy[p], m_rd_busy[p]);
        end
      end
    end
  end

  // ---------------- scoreboard for literal expectations ----------------
  logic [DW-1:0] exp_q[$];

  task automatic check_lit(input string name, input logic [DW-1:0] got);
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rd_en = '0; rd_sel = '0; wr_en = '0; wr_sel = '0; wr_data = '0;
    claim_en = 1'b0; claim_sel = '0;
  endtask

  task automatic rd(input int p, input int s);
    rd_en[p] = 1'b1;
    rd_sel[p*SW +: SW] = SW'(s);
  endtask

  task automatic wr(input int w, input int s, input logic [DW-1:0] d);
    wr_en[w] = 1'b1;
    wr_sel[w*SW +: SW] = SW'(s);
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic claim(input int s);
    claim_en = 1'b1;
    claim_sel = SW'(s);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    step();
    cmp_on = 1'b1;
    rst_n = 1'b1;
    check_lit_reset: begin
      exp_q.push_back('0);
      check_lit("reset_busy_vec", DW'(busy_vec));
    end

    // Reset discards a pending write and claim.
    idle(); wr(0, 5, 32'hDEAD); claim(5); step();
    rst_n = 1'b0; idle(); wr(1, 6, 32'h1); step();
    rst_n = 1'b1; idle(); rd(0, 5); step();
    exp_q.push_back(32'h0); check_lit("t1_rd_r5", rd_data[0 +: DW]);
    exp_q.push_back(32'h0); check_lit("t1_busy_vec", DW'(busy_vec));

    // Same-cycle bypass then stored value.
    idle(); wr(0, 3, 32'h1234); rd(1, 3); step();
    exp_q.push_back(32'h1234); check_lit("t2_bypass", rd_data[DW +: DW]);
    idle(); rd(0, 3); step();
    exp_q.push_back(32'h1234); check_lit("t2_stored", rd_data[0 +: DW]);

    // Collision: port 1 wins.
    idle(); wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(2, 7); step();
    exp_q.push_back(32'h5555); check_lit("t3_bypass", rd_data[2*DW +: DW]);
    idle(); rd(0, 7); step();
    exp_q.push_back(32'h5555); check_lit("t3_stored", rd_data[0 +: DW]);

    // Register zero.
    idle(); wr(0, 0, 32'hFFFF_FFFF); claim(0); rd(1, 0); step();
    exp_q.push_back(32'h0); check_lit("t4_bypass_r0", rd_data[DW +: DW]);
    idle(); rd(1, 0); step();
    exp_q.push_back(32'h0); check_lit("t4_rd_r0", rd_data[DW +: DW]);
    exp_q.push_back(32'h0); check_lit("t4_busy0", DW'(busy_vec[0]));

    // Scoreboard.
    idle(); claim(4); step();
    exp_q.push_back(DW'(SB)); check_lit("t5_claim", DW'(busy_vec[4]));
    idle(); wr(0, 4, 32'd9); claim(4); step();
    exp_q.push_back(DW'(SB)); check_lit("t5_claim_beats_wr", DW'(busy_vec[4]));
    idle(); wr(1, 4, 32'd10); step();
    exp_q.push_back(32'h0); check_lit("t5_wr_clears", DW'(busy_vec[4]));
    idle(); rd(0, 4); step();
    exp_q.push_back(32'd10); check_lit("t5_rd_data", rd_data[0 +: DW]);
    exp_q.push_back(32'h0);  check_lit("t5_rd_busy", DW'(rd_busy[0]));
    idle(); claim(6); rd(2, 6); step();
    exp_q.push_back(DW'(SB)); check_lit("t5_rd_claim_bypass", DW'(rd_busy[2]));

    // Hold when rd_en is low.
    idle(); wr(0, 2, 32'h77); step();
    idle(); rd(0, 2); step();
    exp_q.push_back(32'h77); check_lit("t6_read", rd_data[0 +: DW]);
    idle(); wr(0, 2, 32'h88); step();
    exp_q.push_back(32'h77); check_lit("t6_hold", rd_data[0 +: DW]);
    idle(); step();
    exp_q.push_back(32'h77); check_lit("t6_hold2", rd_data[0 +: DW]);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit narrow;
      idle();
      narrow = ($urandom_range(0, 1) == 1);
      rst_n = ($urandom_range(0, 49) != 0);
      for (int p = 0; p < NRP; p++) begin
        rd_en[p] = ($urandom_range(0, 3) != 0);
        rd_sel[p*SW +: SW] = narrow ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, NR-1));
      end
      for (int w = 0; w < NWP; w++) begin
        wr_en[w] = ($urandom_range(0, 2) != 0);
        wr_sel[w*SW +: SW] = narrow ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, NR-1));
        wr_data[w*DW +: DW] = $urandom;
      end
      claim_en = ($urandom_range(0, 1) == 1);
      claim_sel = narrow ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, NR-1));
      step();
    end

    rst_n = 1'b1;
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
